// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - 32x32 register file with per-register result-pending scoreboard
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  rs_busy,
    output logic                  rt_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [ADDR_WIDTH:0]   pending_count
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_valid;
    logic                  issue_valid;

    assign wr_valid    = wr_en && (wr_addr != '0);
    assign issue_valid = issue_en && (issue_addr != '0);

    // Issue is applied after the writeback clear so a newer reservation wins.
    always_comb begin
        busy_next = busy;
        if (wr_valid) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy          <= '0;
            pending_count <= '0;
        end else begin
            if (wr_valid) begin
                regs[wr_addr] <= wr_data;
            end
            busy          <= busy_next;
            pending_count <= count_next;
        end
    end

    // Writeback bypass makes the result and the cleared hazard visible in the writing cycle.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = (wr_en && (wr_addr == rs_addr)) ? wr_data : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = (wr_en && (wr_addr == rt_addr)) ? wr_data : regs[rt_addr];
        end
    end

    assign rs_busy = (rs_addr != '0) && busy[rs_addr] && !(wr_en && (wr_addr == rs_addr));
    assign rt_busy = (rt_addr != '0) && busy[rt_addr] && !(wr_en && (wr_addr == rt_addr));

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed vector bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr, issue_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        rs_busy, rt_busy, wr_en, issue_en;
    logic [5:0]  pending_count;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        bit          chk;
        logic        reset;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        issue_en;
        logic [4:0]  issue_addr;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] e_rs_data;
        logic [31:0] e_rt_data;
        logic        e_rs_busy;
        logic        e_rt_busy;
        logic [5:0]  e_count;
    } vec_t;

    vec_t vecs[17];

    reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; rs_addr = ra; rt_addr = rb;
        #1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        drive(v.reset, v.wr_en, v.wr_addr, v.wr_data, v.issue_en, v.issue_addr, v.rs_addr, v.rt_addr);
        if (v.chk) begin
            check($sformatf("v%0d rs_data", idx), rs_data, v.e_rs_data);
            check($sformatf("v%0d rt_data", idx), rt_data, v.e_rt_data);
            check($sformatf("v%0d rs_busy", idx), {31'd0, rs_busy}, {31'd0, v.e_rs_busy});
            check($sformatf("v%0d rt_busy", idx), {31'd0, rt_busy}, {31'd0, v.e_rt_busy});
            check($sformatf("v%0d count", idx), {26'd0, pending_count}, {26'd0, v.e_count});
        end
    endtask

    initial begin
        //            chk rst we  wa     wd            ie  ia     rs     rt     e_rs          e_rt          rsb  rtb  cnt
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'd5, 32'haaaaaaaa, 1'b0, 5'd0, 5'd5, 5'd5, 32'haaaaaaaa, 32'haaaaaaaa, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'haaaaaaaa, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 5'd0, 32'hffffffff, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'haaaaaaaa, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd7, 32'hbbbbbbbb, 1'b0, 5'd0, 5'd7, 5'd7, 32'hbbbbbbbb, 32'hbbbbbbbb, 1'b0, 1'b0, 6'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'hbbbbbbbb, 32'hbbbbbbbb, 1'b0, 1'b0, 6'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 5'd9, 32'hcccccccc, 1'b1, 5'd9, 5'd9, 5'd9, 32'hcccccccc, 32'hcccccccc, 1'b0, 1'b0, 6'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'hcccccccc, 32'hcccccccc, 1'b1, 1'b1, 6'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'hcccccccc, 1'b0, 1'b1, 6'd1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'hcccccccc, 1'b0, 1'b1, 6'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 5'd9, 32'hdddddddd, 1'b0, 5'd0, 5'd5, 5'd9, 32'haaaaaaaa, 32'hdddddddd, 1'b0, 1'b0, 6'd1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5, 32'hdddddddd, 32'haaaaaaaa, 1'b0, 1'b0, 6'd0};

        for (int i = 0; i < 17; i++) begin
            apply(i, vecs[i]);
        end

        // Fill every reservable register, one per edge.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(i), 5'd0);
            check($sformatf("fill%0d count", i), {26'd0, pending_count}, 32'(i - 1));
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd31, 5'd1);
        check("fill count31", {26'd0, pending_count}, 32'd31);
        check("fill rs_busy31", {31'd0, rs_busy}, 32'd1);
        check("fill rt_busy1", {31'd0, rt_busy}, 32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd4);
        check("issue0 count", {26'd0, pending_count}, 32'd31);
        check("issue0 rs_busy", {31'd0, rs_busy}, 32'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4);
        check("reissue4 count", {26'd0, pending_count}, 32'd31);
        check("reissue4 busy", {31'd0, rt_busy}, 32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd31);
        check("fill reset count", {26'd0, pending_count}, 32'd0);
        check("fill reset rs_busy", {31'd0, rs_busy}, 32'd0);
        check("fill reset rt_busy", {31'd0, rt_busy}, 32'd0);

        // Mid-operation reset with three outstanding reservations and live data.
        drive(1'b0, 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd2, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd4, 5'd2, 5'd4);
        check("mid data2", rs_data, 32'h22222222);
        check("mid busy2", {31'd0, rs_busy}, 32'd1);
        drive(1'b1, 1'b1, 5'd3, 32'h99999999, 1'b1, 5'd2, 5'd3, 5'd4);
        check("mid count3", {26'd0, pending_count}, 32'd3);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
            check($sformatf("rst rs_data%0d", a), rs_data, 32'h0);
            check($sformatf("rst rt_data%0d", 31 - a), rt_data, 32'h0);
            check($sformatf("rst rs_busy%0d", a), {31'd0, rs_busy}, 32'd0);
            check($sformatf("rst rt_busy%0d", 31 - a), {31'd0, rt_busy}, 32'd0);
        end
        check("rst count", {26'd0, pending_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
